branch_predictor: RTL and testbench
===================================

# branch_predictor

Direction predictor and redirect source for conditional branches. At decode it supplies the `approx` (predicted-taken) bit that travels with each branch instruction. It later consumes the branch unit's `Result` for that instruction, trains a pattern history table (PHT) of 2-bit saturating counters, and issues a one-cycle front-end redirect on misprediction.

## Interface
Parameters:
- `PHT_ENTRIES`, 64: PHT size; must be a power of two. Index width `PHT_IDX_W = $clog2(PHT_ENTRIES)`.
- `CID_W`, 5: commit_id width. The checkpoint table has `2**CID_W` entries.

Ports:
- `clk` in 1: the single clock.
- `nrst` in 1: asynchronous, active-low reset.
- `pred_valid` in 1: decode requests a prediction this cycle.
- `pred_ready` out 1: the request is accepted when `pred_valid && pred_ready`.
- `pred_pc` in 32: branch instruction PC.
- `pred_commit_id` in CID_W: commit_id allocated to the branch.
- `pred_out_valid` out 1: `pred_approx` is valid.
- `pred_approx` out 1: predicted taken.
- `res_valid` in 1: a `Result` is presented this cycle.
- `res` in Result: branch result; it is a branch only if `kind == 1`.
- `redirect_valid` out 1: one-cycle redirect pulse.
- `redirect_pc` out 32: fetch restart address.

## Operation
- **Index.** `idx = pred_pc[PHT_IDX_W+1:2]`, XORed with the GHR when history is enabled (see Configuration).
- **Prediction.** `pred_approx = pht[idx][1]`.
- **Checkpoint.** On acceptance, write `ckpt[pred_commit_id] = {valid=1, idx, pred, ghr_before}`. An occupied entry is overwritten.
- **Speculative history.** On acceptance, `ghr <= {ghr[GHR_W-2:0], pred}`.
- **Training.** On `res_valid && res.kind == 1`, read `ckpt[res.commit_id]`.
  - If the entry is valid: `pht[idx]` saturates toward `res.content.branch.taken` (00 and 11 saturate). The entry's valid bit is then cleared.
  - If the entry is invalid (for example a `jr`, which never requests a prediction): the PHT and GHR are untouched.
- **Redirect.** If `res.content.branch.miss`, then on the next cycle `redirect_valid = 1` and `redirect_pc = res.content.branch.new_pc`. This holds whether or not the checkpoint entry is valid.
  - If the checkpoint entry was valid, also restore `ghr <= {ckpt.ghr_before[GHR_W-2:0], taken}`.
- **Flow control.** `pred_ready` is low in exactly the cycle `redirect_valid` is high, and high otherwise.
- **Non-branch results.** Results with `kind != 1` are ignored.

## Timing
- Prediction latency is one cycle: accept in cycle N, then `pred_out_valid` and `pred_approx` are registered and valid in N+1 for one cycle.
- Redirect latency is one cycle from `res_valid`. Back-to-back misses give back-to-back pulses.
- **PHT read/write same cycle.** If training writes the PHT entry that a prediction reads in the same cycle, the prediction sees the pre-update value.
- **GHR write priority.** A miss restore and a speculative shift in the same cycle: the restore wins, and the accepted prediction's shift is dropped.
- **Checkpoint write priority.** Training and acceptance on the same commit_id in the same cycle: the new checkpoint write wins, and training uses the old entry contents.
- **Reset values:**
  - PHT entries = 2'b01 (weakly not-taken).
  - GHR = 0; all checkpoint valid bits = 0.
  - `pred_out_valid = 0`, `pred_approx = 0`, `redirect_valid = 0`, `redirect_pc = 0`, `pred_ready = 1`.
- **Reset mid-operation.** Reset asserted mid-operation clears all of the above immediately (asynchronous). Pending checkpoints are lost.

## Configuration
- `BP_GHIST_EN` defined:
  - an 8-bit global history register is built;
  - `idx` is XORed with `ghr[PHT_IDX_W-1:0]` (zero-extended if `PHT_IDX_W > 8`);
  - checkpoints store `ghr_before`.
- `BP_GHIST_EN` undefined: no GHR, no history field in checkpoints, and the index is PC-only (bimodal).

## Structure
- **Shared package:**
  - `PhtCounter` (logic [1:0]) with constants `WNT = 2'b01` and `STRONG_T = 2'b11`;
  - the `BpCheckpoint` struct;
  - `GHR_W = 8`.
- **Sub-module.** `bp_ckpt_table` provides the checkpoint storage: one write port, one asynchronous read port, and a per-entry valid bit cleared by the read side.
- **Main module.** The PHT, GHR and redirect registers live in `branch_predictor`.

## Test plan
- **Reset.** Reset, then a prediction for pc 0x100 → `pred_approx = 0` at N+1; `pred_ready = 1`.
- **Training.** Accept pc 0x100 with commit_id 3; return `taken = 1, miss = 1` twice (fresh predictions between them) → the counter reaches 11 and the next prediction gives `pred_approx = 1`; each miss produces `redirect_valid` for exactly one cycle with the given `new_pc`.
- **Saturation.** Four not-taken results on the same PC → counter 00. A fifth not-taken result leaves it at 00, with no redirect when `miss = 0`.
- **jr result.** A `jr` result (no checkpoint, `miss = 1`, `new_pc = 0x2000`) → redirect to 0x2000 with the PHT unchanged.
- **Collision.** Prediction and training on the same idx in the same cycle → the prediction reflects the old counter; the counter is updated next cycle.
- **Reset mid-miss.** `nrst` low in the cycle after `res` with miss → `redirect_valid` returns to 0 immediately; the checkpoint for that commit_id is invalid after reset.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types for the conditional-branch direction predictor.
//   PhtCounter   - 2-bit saturating counter (WNT = reset value, STRONG_T = max)
//   Result       - branch unit result; only kind == KIND_BRANCH is consumed
//   BpCheckpoint - per-commit_id snapshot taken when a prediction is accepted
// Build option: BP_GHIST_EN adds the ghr_before field to checkpoints.
// Struct fields are sized to package maxima so the package stays parameter-free;
// the predictor uses only the low PHT_IDX_W / CID_W bits.
package branch_predictor_pkg;
  localparam int GHR_W        = 8;
  localparam int BP_IDX_MAX_W = 16;
  localparam int BP_CID_MAX_W = 8;

  typedef logic [1:0] PhtCounter;
  localparam PhtCounter WNT      = 2'b01;
  localparam PhtCounter STRONG_T = 2'b11;

  localparam logic [1:0] KIND_BRANCH = 2'd1;

  typedef struct packed {
    logic        taken;
    logic        miss;
    logic [31:0] new_pc;
  } BranchInfo;

  typedef struct packed {
    BranchInfo branch;
  } ResultContent;

  typedef struct packed {
    logic [1:0]              kind;
    logic [BP_CID_MAX_W-1:0] commit_id;
    ResultContent            content;
  } Result;

  typedef struct packed {
    logic                    valid;
    logic [BP_IDX_MAX_W-1:0] idx;
    logic                    pred;
`ifdef BP_GHIST_EN
    logic [GHR_W-1:0]        ghr_before;
`endif
  } BpCheckpoint;

  // Step a counter one notch toward the outcome, holding at 00 and 11.
  function automatic PhtCounter pht_sat(PhtCounter c, logic taken);
    if (taken) return (c == STRONG_T) ? c : c + 2'd1;
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// Decode / branch-unit <-> predictor bus.
//   master: decode + branch unit (drives requests and results)
//   slave : branch_predictor (drives ready, prediction and redirect)
interface branch_predictor_if #(parameter int CID_W = 5);
  import branch_predictor_pkg::*;
  logic             pred_valid;
  logic             pred_ready;
  logic [31:0]      pred_pc;
  logic [CID_W-1:0] pred_commit_id;
  logic             pred_out_valid;
  logic             pred_approx;
  logic             res_valid;
  Result            res;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;

  modport master (
    output pred_valid, pred_pc, pred_commit_id, res_valid, res,
    input  pred_ready, pred_out_valid, pred_approx, redirect_valid, redirect_pc
  );
  modport slave (
    input  pred_valid, pred_pc, pred_commit_id, res_valid, res,
    output pred_ready, pred_out_valid, pred_approx, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/branch_predictor_ckpt_table.sv
// bp_ckpt_table: checkpoint storage indexed by commit_id.
//   wr_en/wr_cid/wr_data - capture a checkpoint (marks entry valid)
//   rd_cid/rd_data       - asynchronous read, valid bit from the flag vector
//   clr_en               - invalidate the entry at rd_cid
// A write and a clear to the same entry in one cycle leave it valid.
module bp_ckpt_table
  import branch_predictor_pkg::*;
#(
  parameter int CID_W = 5
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             wr_en,
  input  logic [CID_W-1:0] wr_cid,
  input  BpCheckpoint      wr_data,
  input  logic [CID_W-1:0] rd_cid,
  output BpCheckpoint      rd_data,
  input  logic             clr_en
);
  localparam int DEPTH = 2 ** CID_W;

  logic [DEPTH-1:0] vld;
  BpCheckpoint      mem [DEPTH];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) vld <= '0;
    else begin
      if (clr_en) vld[rd_cid] <= 1'b0;
      if (wr_en)  vld[wr_cid] <= 1'b1;   // later assignment: new checkpoint wins
    end
  end

  // Payload needs no reset; only the valid flags matter after reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cid] <= wr_data;
  end

  always_comb begin
    rd_data       = mem[rd_cid];
    rd_data.valid = vld[rd_cid];
  end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit-counter PHT direction predictor with redirect.
//   clk, nrst - clock, async active-low reset
//   bus       - slave side of branch_predictor_if (requests, results, redirect)
// Build option: BP_GHIST_EN builds an 8-bit speculative global history that is
// XORed into the PHT index (gshare); undefined gives a PC-only bimodal index.
// Requires PHT_IDX_W <= BP_IDX_MAX_W and CID_W <= BP_CID_MAX_W.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int PHT_ENTRIES = 64,
  parameter int CID_W       = 5
) (
  input logic               clk,
  input logic               nrst,
  branch_predictor_if.slave bus
);
  localparam int PHT_IDX_W = $clog2(PHT_ENTRIES);

  PhtCounter            pht [PHT_ENTRIES];
  logic [PHT_IDX_W-1:0] idx, tr_idx;
  logic                 accept, pred, is_br, train, miss, taken;
  logic [CID_W-1:0]     res_cid;
  BpCheckpoint          ck_wr, ck_rd;

  // Stall decode for the one cycle the front end is being redirected.
  assign bus.pred_ready = !bus.redirect_valid;

  assign accept  = bus.pred_valid && bus.pred_ready;
  assign res_cid = bus.res.commit_id[CID_W-1:0];
  assign is_br   = bus.res_valid && (bus.res.kind == KIND_BRANCH);
  assign train   = is_br && ck_rd.valid;
  assign miss    = bus.res.content.branch.miss;
  assign taken   = bus.res.content.branch.taken;
  assign tr_idx  = ck_rd.idx[PHT_IDX_W-1:0];

`ifdef BP_GHIST_EN
  logic [GHR_W-1:0]     ghr;
  logic [PHT_IDX_W-1:0] hist;
  if (PHT_IDX_W > GHR_W) begin : g_hist_ext
    assign hist = {{(PHT_IDX_W-GHR_W){1'b0}}, ghr};
  end else begin : g_hist_trunc
    assign hist = ghr[PHT_IDX_W-1:0];
  end
  assign idx = bus.pred_pc[PHT_IDX_W+1:2] ^ hist;
`else
  assign idx = bus.pred_pc[PHT_IDX_W+1:2];
`endif

  // Combinational read of the pre-update array: a same-cycle train to this
  // entry is not visible to the prediction.
  assign pred = pht[idx][1];

  always_comb begin
    ck_wr       = '0;
    ck_wr.valid = 1'b1;
    ck_wr.idx   = BP_IDX_MAX_W'(idx);
    ck_wr.pred  = pred;
`ifdef BP_GHIST_EN
    ck_wr.ghr_before = ghr;
`endif
  end

  bp_ckpt_table #(.CID_W(CID_W)) u_ckpt (
    .clk     (clk),
    .nrst    (nrst),
    .wr_en   (accept),
    .wr_cid  (bus.pred_commit_id),
    .wr_data (ck_wr),
    .rd_cid  (res_cid),
    .rd_data (ck_rd),
    .clr_en  (train)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= WNT;
    end else if (train) begin
      pht[tr_idx] <= pht_sat(pht[tr_idx], taken);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bus.pred_out_valid <= 1'b0;
      bus.pred_approx    <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
    end else begin
      bus.pred_out_valid <= accept;
      bus.pred_approx    <= accept & pred;
      // Redirect does not depend on the checkpoint (covers jr).
      bus.redirect_valid <= is_br && miss;
      if (is_br && miss) bus.redirect_pc <= bus.res.content.branch.new_pc;
    end
  end

`ifdef BP_GHIST_EN
  // Miss restore rebuilds history from the checkpoint and beats the shift.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)               ghr <= '0;
    else if (train && miss)  ghr <= {ck_rd.ghr_before[GHR_W-2:0], taken};
    else if (accept)         ghr <= {ghr[GHR_W-2:0], pred};
  end
`endif

  // PC bits outside the index, upper commit_id bits and checkpoint fields
  // kept for debug are intentionally not consumed.
  logic unused_bits;
  assign unused_bits = ^{ck_rd, bus.pred_pc, bus.res.commit_id};
endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  localparam int PHT_ENTRIES = 64;
  localparam int CID_W       = 5;
  localparam int NCID        = 2 ** CID_W;

  logic clk  = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_if #(.CID_W(CID_W)) bus ();
  branch_predictor #(.PHT_ENTRIES(PHT_ENTRIES), .CID_W(CID_W)) dut (
    .clk(clk), .nrst(nrst), .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: counters as plain integers 0..3, checkpoints as arrays.
  int          m_pht [PHT_ENTRIES];
  bit          m_cv  [NCID];
  int          m_cidx[NCID];
  int          m_cghr[NCID];
  int          m_ghr;
  bit          m_rv;
  logic [31:0] m_rpc;

  function automatic void model_reset();
    for (int i = 0; i < PHT_ENTRIES; i++) m_pht[i] = 1;
    for (int i = 0; i < NCID; i++) begin m_cv[i] = 0; m_cidx[i] = 0; m_cghr[i] = 0; end
    m_ghr = 0; m_rv = 0; m_rpc = 0;
  endfunction

  task automatic set_pred(bit v, logic [31:0] pc, int cid);
    bus.pred_valid = v; bus.pred_pc = pc; bus.pred_commit_id = CID_W'(cid);
  endtask

  task automatic set_res(bit v, int kind, int cid, bit tk, bit ms, logic [31:0] npc);
    Result r;
    r = '0;
    r.kind = 2'(kind);
    r.commit_id = BP_CID_MAX_W'(cid);
    r.content.branch.taken  = tk;
    r.content.branch.miss   = ms;
    r.content.branch.new_pc = npc;
    bus.res_valid = v; bus.res = r;
  endtask

  task automatic idle();
    set_pred(0, 0, 0); set_res(0, 0, 0, 0, 0, 0);
  endtask

  // One clock: predict expected outputs from the model, advance, compare.
  task automatic cycle();
    bit rdy, acc, pred, br, ckv, tk, ms;
    int idx, cid, ti, g0, pcid;
    rdy = !m_rv;
    chk("pred_ready", bus.pred_ready, rdy);
    acc = bus.pred_valid && rdy;
    idx = int'((bus.pred_pc >> 2) % PHT_ENTRIES);
`ifdef BP_GHIST_EN
    idx = idx ^ (m_ghr % PHT_ENTRIES);
`endif
    pred = m_pht[idx] >= 2;
    br   = bus.res_valid && bus.res.kind == 2'd1;
    cid  = int'(bus.res.commit_id) % NCID;
    ckv  = br && m_cv[cid];
    tk   = bus.res.content.branch.taken;
    ms   = bus.res.content.branch.miss;
    ti   = m_cidx[cid];
    g0   = m_ghr;
    if (ckv) begin
      if (tk) m_pht[ti] = (m_pht[ti] < 3) ? m_pht[ti] + 1 : 3;
      else    m_pht[ti] = (m_pht[ti] > 0) ? m_pht[ti] - 1 : 0;
      m_cv[cid] = 0;
    end
    if (ckv && ms) m_ghr = ((m_cghr[cid] * 2) + tk) % 256;
    else if (acc)  m_ghr = ((g0 * 2) + pred) % 256;
    if (acc) begin
      pcid = int'(bus.pred_commit_id);
      m_cv[pcid] = 1; m_cidx[pcid] = idx; m_cghr[pcid] = g0;
    end
    m_rv = br && ms;
    if (m_rv) m_rpc = bus.res.content.branch.new_pc;
    @(posedge clk); #1;
    chk("pred_out_valid", bus.pred_out_valid, acc);
    chk("pred_approx", bus.pred_approx, acc && pred);
    chk("redirect_valid", bus.redirect_valid, m_rv);
    if (m_rv) chk("redirect_pc", bus.redirect_pc, m_rpc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle(); model_reset();
    #1 nrst = 1'b0;
    #10;
    chk("rst_out_valid", bus.pred_out_valid, 0);
    chk("rst_approx", bus.pred_approx, 0);
    chk("rst_redirect", bus.redirect_valid, 0);
    chk("rst_redirect_pc", bus.redirect_pc, 0);
    chk("rst_ready", bus.pred_ready, 1);
    nrst = 1'b1;

    // First prediction after reset: weakly not-taken.
    set_pred(1, 32'h100, 3); cycle();
    chk("first_approx", bus.pred_approx, 0);

    // Two taken misses, fresh prediction in between.
    idle(); set_res(1, 1, 3, 1, 1, 32'h104); cycle();
    chk("miss1_pc", bus.redirect_pc, 32'h104);
    idle(); cycle();
    set_pred(1, 32'h100, 3); cycle();
    idle(); set_res(1, 1, 3, 1, 1, 32'h108); cycle();
    idle(); cycle();
    set_pred(1, 32'h100, 4); cycle();
`ifndef BP_GHIST_EN
    chk("train_approx", bus.pred_approx, 1);
`endif

    // Saturation toward not-taken, no redirect since miss = 0.
    for (int k = 0; k < 5; k++) begin
      idle(); set_res(1, 1, 4, 0, 0, 0); cycle();
      idle(); set_pred(1, 32'h100, 4); cycle();
    end
`ifndef BP_GHIST_EN
    chk("sat_approx", bus.pred_approx, 0);
`endif

    // jr: no checkpoint, still redirects.
    idle(); set_res(1, 1, 20, 1, 1, 32'h2000); cycle();
    chk("jr_redirect", bus.redirect_valid, 1);
    chk("jr_redirect_pc", bus.redirect_pc, 32'h2000);
    idle(); cycle();

    // Same-cycle train and predict on one entry.
    set_pred(1, 32'h180, 12); cycle();
    set_pred(1, 32'h180, 13); set_res(1, 1, 12, 1, 0, 0); cycle();
`ifndef BP_GHIST_EN
    chk("coll_old", bus.pred_approx, 0);
`endif
    idle(); set_pred(1, 32'h180, 14); cycle();
`ifndef BP_GHIST_EN
    chk("coll_new", bus.pred_approx, 1);
`endif

    // Reset during a redirect pulse; pending checkpoint 8 is lost.
    idle(); cycle();
    set_pred(1, 32'h300, 7); cycle();
    set_pred(1, 32'h300, 8); cycle();
    idle(); set_res(1, 1, 7, 1, 1, 32'h400); cycle();
    idle(); nrst = 1'b0; #1;
    chk("midrst_redirect", bus.redirect_valid, 0);
    chk("midrst_ready", bus.pred_ready, 1);
    model_reset();
    #3 nrst = 1'b1;
    set_res(1, 1, 8, 1, 0, 0); cycle();
    idle(); set_pred(1, 32'h300, 9); cycle();
    chk("midrst_ckpt", bus.pred_approx, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      set_pred($urandom_range(0, 1), $urandom & 32'h1fc, $urandom_range(0, NCID - 1));
      set_res($urandom_range(0, 2) != 0, $urandom_range(0, 3), $urandom_range(0, 255),
              $urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
